// File: rtl/tmp_readout.sv
// Temperature-sensor readout: counts source/sink toggles per frame, averages
// the signed difference over 2^AVG_LOG2 frames and queues words in a FIFO.
module tmp_readout #(
  parameter int CNT_W      = 8,
  parameter int AVG_LOG2   = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             frame_active,
  input  logic             snk,
  input  logic             src_n,
  output logic [CNT_W:0]   out_data,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             busy
);
  // state | meaning
  // IDLE  | waiting for frame_active; entry cycle already counts events
  // COUNT | counting toggles until frame_active falls
  // CLOSE | fold src-snk difference into the accumulator
  // PUSH  | write averaged word (and sat flag) into the FIFO

  localparam int ACC_W = CNT_W + 1 + AVG_LOG2;
  localparam int FI_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [FI_W-1:0]  FI_LAST = FI_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, COUNT, CLOSE, PUSH} state_t;
  typedef logic [CNT_W+1:0] entry_t;

  state_t                   state_q, state_d;
  logic                     snk_q, snk_d, src_n_q, src_n_d;
  logic [CNT_W-1:0]         src_cnt_q, src_cnt_d, snk_cnt_q, snk_cnt_d;
  logic                     sat_q, sat_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [FI_W-1:0]          fidx_q, fidx_d;
  entry_t                   mem_q [FIFO_DEPTH];
  entry_t                   mem_d [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]              cnt_q, cnt_d;
  logic                     overrun_q, overrun_d;
  entry_t                   last_q, last_d;

  logic                     snk_evt, src_evt, count_en, push, pop, full, do_wr;
  logic signed [CNT_W:0]    diff_s;
  logic [CNT_W:0]           result;

  always_comb begin
    state_d   = state_q;
    snk_d     = snk;
    src_n_d   = src_n;
    src_cnt_d = src_cnt_q;
    snk_cnt_d = snk_cnt_q;
    sat_d     = sat_q;
    acc_d     = acc_q;
    fidx_d    = fidx_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    last_d    = last_q;

    snk_evt  = snk ^ snk_q;
    src_evt  = src_n ^ src_n_q;
    count_en = frame_active && (state_q == IDLE || state_q == COUNT);
    diff_s   = $signed({1'b0, src_cnt_q}) - $signed({1'b0, snk_cnt_q});
    result   = (CNT_W+1)'(acc_q >>> AVG_LOG2);

    if (count_en) begin
      if (src_evt) begin
        if (src_cnt_q == CNT_MAX) sat_d = 1'b1;
        else                      src_cnt_d = src_cnt_q + 1'b1;
      end
      if (snk_evt) begin
        if (snk_cnt_q == CNT_MAX) sat_d = 1'b1;
        else                      snk_cnt_d = snk_cnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE:  if (frame_active) state_d = COUNT;
      COUNT: if (!frame_active) state_d = CLOSE;
      CLOSE: begin
        acc_d     = acc_q + ACC_W'(diff_s);
        src_cnt_d = '0;
        snk_cnt_d = '0;
        if (fidx_q == FI_LAST) begin
          fidx_d  = '0;
          state_d = PUSH;
        end else begin
          fidx_d  = fidx_q + 1'b1;
          state_d = IDLE;
        end
      end
      PUSH: begin
        acc_d   = '0;
        sat_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A full FIFO still accepts the new word when the head leaves this cycle.
    push  = (state_q == PUSH);
    pop   = out_valid && out_ready;
    full  = (cnt_q == FULL_CNT);
    do_wr = push && (!full || pop);
    if (push && full && !pop) overrun_d = 1'b1;
    if (do_wr) begin
      mem_d[wr_ptr_q] = {result, sat_q};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + (AW+1)'(do_wr) - (AW+1)'(pop);

    if (clear) begin
      state_d   = IDLE;
      snk_d     = 1'b0;
      src_n_d   = 1'b0;
      src_cnt_d = '0;
      snk_cnt_d = '0;
      sat_d     = 1'b0;
      acc_d     = '0;
      fidx_d    = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
      overrun_d = 1'b0;
      last_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      snk_q     <= 1'b0;
      src_n_q   <= 1'b0;
      src_cnt_q <= '0;
      snk_cnt_q <= '0;
      sat_q     <= 1'b0;
      acc_q     <= '0;
      fidx_q    <= '0;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      snk_q     <= snk_d;
      src_n_q   <= src_n_d;
      src_cnt_q <= src_cnt_d;
      snk_cnt_q <= snk_cnt_d;
      sat_q     <= sat_d;
      acc_q     <= acc_d;
      fidx_q    <= fidx_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      last_q    <= last_d;
    end
  end

  // Empty FIFO keeps presenting the most recently popped word.
  assign out_valid           = (cnt_q != '0);
  assign {out_data, out_sat} = out_valid ? mem_q[rd_ptr_q] : last_q;
  assign overrun             = overrun_q;
  assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_tmp_readout.sv
// Directed bench for tmp_readout: one instance without averaging, one
// averaging over four frames, both driven from the same stimulus.
module tb_tmp_readout;
  logic clk = 1'b0;
  logic reset, clear, frame_active, snk, src_n, out_ready;
  logic [8:0] d0, d2;
  logic sat0, sat2, v0, v2, ovr0, ovr2, busy0, busy2;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tmp_readout #(.CNT_W(8), .AVG_LOG2(0), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .reset(reset), .clear(clear), .frame_active(frame_active),
    .snk(snk), .src_n(src_n), .out_data(d0), .out_sat(sat0), .out_valid(v0),
    .out_ready(out_ready), .overrun(ovr0), .busy(busy0));

  tmp_readout #(.CNT_W(8), .AVG_LOG2(2), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .reset(reset), .clear(clear), .frame_active(frame_active),
    .snk(snk), .src_n(src_n), .out_data(d2), .out_sat(sat2), .out_valid(v2),
    .out_ready(out_ready), .overrun(ovr2), .busy(busy2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0; tick();
  endtask

  task automatic do_pop();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  // One frame: nsrc/nsnk toggles, then close; the word is in the FIFO on return.
  task automatic run_frame(input int nsrc, input int nsnk, input bit pop_on_push);
    int n;
    n = (nsrc > nsnk) ? nsrc : nsnk;
    if (n < 1) n = 1;
    frame_active = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i < nsrc) src_n = ~src_n;
      if (i < nsnk) snk = ~snk;
      tick();
    end
    frame_active = 1'b0;
    tick();
    tick();
    out_ready = pop_on_push;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; frame_active = 1'b0; snk = 1'b0; src_n = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", v0); end
    checks++; if (d0 !== 9'd0 || sat0 !== 1'b0) begin failures++; $display("FAIL rst_data got=%0d/%b exp=0/0", d0, sat0); end
    checks++; if (ovr0 !== 1'b0 || busy0 !== 1'b0 || busy2 !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b%b exp=000", ovr0, busy0, busy2); end
  endtask

  task automatic test_basic();
    do_clear();
    frame_active = 1'b1;
    for (int i = 0; i < 10; i++) begin
      src_n = ~src_n;
      if (i < 4) snk = ~snk;
      tick();
    end
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL basic_busy_count got=%b exp=1", busy0); end
    frame_active = 1'b0;
    tick();
    tick();
    checks++; if (v0 !== 1'b0 || busy0 !== 1'b1) begin failures++; $display("FAIL basic_push_cycle got v=%b busy=%b exp v=0 busy=1", v0, busy0); end
    tick();
    checks++; if (v0 !== 1'b1 || busy0 !== 1'b0) begin failures++; $display("FAIL basic_latency got v=%b busy=%b exp v=1 busy=0", v0, busy0); end
    checks++; if (d0 !== 9'd6 || sat0 !== 1'b0) begin failures++; $display("FAIL basic_data got=%0d/%b exp=6/0", d0, sat0); end
    do_pop();
    checks++; if (v0 !== 1'b0 || d0 !== 9'd6) begin failures++; $display("FAIL basic_pop got v=%b d=%0d exp v=0 d=6", v0, d0); end
  endtask

  task automatic test_average();
    do_clear();
    run_frame(3, 0, 0);
    checks++; if (v2 !== 1'b0) begin failures++; $display("FAIL avg_f1_valid got=%b exp=0", v2); end
    run_frame(5, 0, 0);
    checks++; if (v2 !== 1'b0) begin failures++; $display("FAIL avg_f2_valid got=%b exp=0", v2); end
    run_frame(0, 2, 0);
    checks++; if (v2 !== 1'b0) begin failures++; $display("FAIL avg_f3_valid got=%b exp=0", v2); end
    run_frame(6, 0, 0);
    checks++; if (v2 !== 1'b1 || d2 !== 9'd3) begin failures++; $display("FAIL avg_pos got v=%b d=%0d exp v=1 d=3", v2, d2); end
    do_pop();
    run_frame(0, 1, 0);
    run_frame(0, 2, 0);
    run_frame(0, 1, 0);
    run_frame(0, 1, 0);
    checks++; if (v2 !== 1'b1 || d2 !== 9'h1FE || sat2 !== 1'b0) begin failures++; $display("FAIL avg_neg got v=%b d=%h sat=%b exp v=1 d=1fe sat=0", v2, d2, sat2); end
    do_pop();
  endtask

  task automatic test_simultaneous();
    do_clear();
    frame_active = 1'b1;
    for (int i = 0; i < 7; i++) begin
      src_n = ~src_n; snk = ~snk; tick();
    end
    frame_active = 1'b0;
    src_n = ~src_n;
    tick(); tick(); tick();
    checks++; if (v0 !== 1'b1 || d0 !== 9'd0 || sat0 !== 1'b0) begin failures++; $display("FAIL simul got v=%b d=%0d sat=%b exp v=1 d=0 sat=0", v0, d0, sat0); end
    do_pop();
  endtask

  task automatic test_saturation();
    do_clear();
    run_frame(300, 0, 0);
    checks++; if (d0 !== 9'd255 || sat0 !== 1'b1) begin failures++; $display("FAIL sat_hi got=%0d/%b exp=255/1", d0, sat0); end
    do_pop();
    run_frame(1, 0, 0);
    checks++; if (d0 !== 9'd1 || sat0 !== 1'b0) begin failures++; $display("FAIL sat_next got=%0d/%b exp=1/0", d0, sat0); end
    do_pop();
  endtask

  task automatic test_overrun();
    do_clear();
    for (int k = 1; k <= 5; k++) run_frame(k, 0, 0);
    checks++; if (ovr0 !== 1'b1 || v0 !== 1'b1) begin failures++; $display("FAIL ovr_set got ovr=%b v=%b exp 1/1", ovr0, v0); end
    for (int k = 1; k <= 4; k++) begin
      checks++; if (d0 !== 9'(k)) begin failures++; $display("FAIL ovr_drain got=%0d exp=%0d", d0, k); end
      do_pop();
    end
    checks++; if (v0 !== 1'b0 || d0 !== 9'd4) begin failures++; $display("FAIL ovr_empty got v=%b d=%0d exp v=0 d=4", v0, d0); end
    checks++; if (ovr0 !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", ovr0); end
    do_clear();
    for (int k = 1; k <= 4; k++) run_frame(k, 0, 0);
    checks++; if (ovr0 !== 1'b0) begin failures++; $display("FAIL full_no_ovr got=%b exp=0", ovr0); end
    run_frame(5, 0, 1);
    checks++; if (ovr0 !== 1'b0 || d0 !== 9'd2) begin failures++; $display("FAIL full_pushpop got ovr=%b d=%0d exp ovr=0 d=2", ovr0, d0); end
    for (int k = 2; k <= 5; k++) begin
      checks++; if (v0 !== 1'b1 || d0 !== 9'(k)) begin failures++; $display("FAIL full_drain got v=%b d=%0d exp v=1 d=%0d", v0, d0, k); end
      do_pop();
    end
    checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL full_count got v=%b exp=0", v0); end
  endtask

  task automatic test_reset_mid_frame();
    do_clear();
    run_frame(2, 0, 0);
    frame_active = 1'b1;
    for (int i = 0; i < 5; i++) begin
      src_n = ~src_n; tick();
    end
    checks++; if (busy0 !== 1'b1 || v0 !== 1'b1) begin failures++; $display("FAIL midrst_pre got busy=%b v=%b exp 1/1", busy0, v0); end
    reset = 1'b1; src_n = 1'b0; snk = 1'b0;
    #1;
    checks++; if (busy0 !== 1'b0 || v0 !== 1'b0 || d0 !== 9'd0 || ovr0 !== 1'b0) begin failures++; $display("FAIL midrst_out got busy=%b v=%b d=%0d ovr=%b exp 0/0/0/0", busy0, v0, d0, ovr0); end
    tick(); tick();
    reset = 1'b0;
    run_frame(3, 0, 0);
    checks++; if (v0 !== 1'b1 || d0 !== 9'd3) begin failures++; $display("FAIL midrst_fresh got v=%b d=%0d exp v=1 d=3", v0, d0); end
  endtask

  task automatic test_clear();
    do_clear();
    for (int k = 1; k <= 5; k++) run_frame(k, 0, 0);
    checks++; if (ovr0 !== 1'b1) begin failures++; $display("FAIL clr_pre got ovr=%b exp=1", ovr0); end
    clear = 1'b1; tick(); clear = 1'b0;
    checks++; if (v0 !== 1'b0 || ovr0 !== 1'b0 || d0 !== 9'd0 || busy0 !== 1'b0) begin failures++; $display("FAIL clr_post got v=%b ovr=%b d=%0d busy=%b exp 0/0/0/0", v0, ovr0, d0, busy0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_average();
    test_simultaneous();
    test_saturation();
    test_overrun();
    test_reset_mid_frame();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
